// File: rtl/counter_sync_up_mod_if.sv
// rtl/counter_sync_up_mod_if.sv - control and status bundle for one counter stage
// Purpose: groups the per-stage control inputs and count/status outputs.
// Signals:
//   En       local count enable
//   CarryIn  cascade enable from the lower stage (tie 1 when unused)
//   Load     synchronous parallel load strobe
//   LoadVal  value taken on Load (clamped to MODULUS-1 by the counter)
//   count    registered current count
//   CarryOut combinational En & CarryIn & (count == MODULUS-1)
//   Wrapped  sticky wrap flag
// Modports: master drives controls and observes status; slave is the counter.
interface counter_sync_up_mod_if #(
  parameter int WIDTH = 4
);
  logic             En;
  logic             CarryIn;
  logic             Load;
  logic [WIDTH-1:0] LoadVal;
  logic [WIDTH-1:0] count;
  logic             CarryOut;
  logic             Wrapped;

  modport master (
    output En, CarryIn, Load, LoadVal,
    input  count, CarryOut, Wrapped
  );

  modport slave (
    input  En, CarryIn, Load, LoadVal,
    output count, CarryOut, Wrapped
  );
endinterface

// File: rtl/counter_sync_up_mod.sv
// rtl/counter_sync_up_mod.sv - synchronous cascadable modulo-N up counter
// Purpose: counts 0..MODULUS-1 on Clk with parallel load, count enable,
//          cascade carry in/out and a sticky wrap flag.
// Ports:
//   Clk  clock, all state updates on posedge
//   Clr  synchronous active-high clear (highest priority)
//   bus  counter_sync_up_mod_if slave: En, CarryIn, Load, LoadVal in;
//        count, CarryOut, Wrapped out
// Priority per edge: Clr > Load > step (En & CarryIn) > hold.
module counter_sync_up_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic                 Clk,
  input  logic                 Clr,
  counter_sync_up_mod_if.slave bus
);
  localparam int               EXT     = WIDTH + 1;
  localparam logic [WIDTH:0]   MOD_EXT = EXT'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic             wrapped_q;
  logic [WIDTH:0]   inc;
  logic             at_top;
  logic             step;
  logic [WIDTH-1:0] load_clamped;

  // The increment carries one extra bit so that MODULUS == 2**WIDTH is
  // detected by the same compare as any smaller modulus.
  always_comb begin
    inc          = {1'b0, count_q} + EXT'(1);
    at_top       = (inc == MOD_EXT);
    step         = bus.En & bus.CarryIn;
    load_clamped = ({1'b0, bus.LoadVal} < MOD_EXT) ? bus.LoadVal : TOP;
  end

  // Clr is tested first so unknown En/CarryIn cannot reach the state.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else if (bus.Load) begin
      count_q   <= load_clamped;
      wrapped_q <= 1'b0;
    end else if (step) begin
      if (at_top) begin
        count_q   <= '0;
        wrapped_q <= 1'b1;
      end else begin
        count_q   <= inc[WIDTH-1:0];
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.Wrapped  = wrapped_q;
  assign bus.CarryOut = step & at_top;
endmodule

// File: tb/tb_counter_sync_up_mod.sv
// tb/tb_counter_sync_up_mod.sv - scoreboard bench for counter_sync_up_mod
module tb_counter_sync_up_mod;
  localparam int W = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  counter_sync_up_mod_if #(.WIDTH(W)) b16 ();
  counter_sync_up_mod_if #(.WIDTH(W)) b10 ();
  counter_sync_up_mod_if #(.WIDTH(W)) blo ();
  counter_sync_up_mod_if #(.WIDTH(W)) bhi ();

  counter_sync_up_mod #(.WIDTH(W), .MODULUS(16)) u16 (.Clk(clk), .Clr(clr), .bus(b16));
  counter_sync_up_mod #(.WIDTH(W), .MODULUS(10)) u10 (.Clk(clk), .Clr(clr), .bus(b10));
  counter_sync_up_mod #(.WIDTH(W), .MODULUS(10)) ulo (.Clk(clk), .Clr(clr), .bus(blo));
  counter_sync_up_mod #(.WIDTH(W), .MODULUS(10)) uhi (.Clk(clk), .Clr(clr), .bus(bhi));

  assign bhi.CarryIn = blo.CarryOut;

  typedef struct {
    logic [3:0] c16; logic w16;
    logic [3:0] c10; logic w10;
    logic [3:0] clo; logic wlo;
    logic [3:0] chi; logic whi;
  } exp_t;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic started = 1'b0;

  logic [3:0] m16c = 4'd0, m10c = 4'd0, mloc = 4'd0, mhic = 4'd0;
  logic       m16w = 1'b0, m10w = 1'b0, mlow = 1'b0, mhiw = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: returns {next_count, next_wrapped}.
  function automatic logic [4:0] nxt(input logic [3:0] c, input logic w, input logic cl,
                                     input logic ld, input logic [3:0] lv, input logic st,
                                     input int m);
    if (cl) return 5'd0;
    if (ld) return {((int'(lv) < m) ? lv : 4'(m - 1)), 1'b0};
    if (st) return (int'(c) == m - 1) ? 5'b0000_1 : {c + 4'd1, w};
    return {c, w};
  endfunction

  task automatic cycle(input logic cl, input logic ld, input logic [3:0] lv,
                       input logic en, input logic ci, input logic xin);
    exp_t e;
    logic [4:0] r;
    logic lo_co;
    @(negedge clk);
    clr = cl;
    b16.Load = ld; b16.LoadVal = lv;
    b10.Load = ld; b10.LoadVal = lv;
    if (cl && xin) begin
      b16.En = 1'bx; b16.CarryIn = 1'bx;
      b10.En = 1'bx; b10.CarryIn = 1'bx;
    end else begin
      b16.En = en; b16.CarryIn = ci;
      b10.En = en; b10.CarryIn = ci;
    end
    blo.En = en;
    bhi.En = en;
    #1;
    lo_co = en & (mloc == 4'd9);
    if (started) begin
      if (!(cl && xin)) begin
        check("co16", 32'(b16.CarryOut), 32'(en & ci & (m16c == 4'd15)));
        check("co10", 32'(b10.CarryOut), 32'(en & ci & (m10c == 4'd9)));
      end
      check("colo", 32'(blo.CarryOut), 32'(lo_co));
      check("cohi", 32'(bhi.CarryOut), 32'(en & lo_co & (mhic == 4'd9)));
    end
    r = nxt(m16c, m16w, cl, ld, lv, en & ci, 16); {e.c16, e.w16} = r;
    r = nxt(m10c, m10w, cl, ld, lv, en & ci, 10); {e.c10, e.w10} = r;
    r = nxt(mloc, mlow, cl, 1'b0, 4'd0, en, 10);  {e.clo, e.wlo} = r;
    r = nxt(mhic, mhiw, cl, 1'b0, 4'd0, lo_co, 10); {e.chi, e.whi} = r;
    sbq.push_back(e);
    {m16c, m16w, m10c, m10w} = {e.c16, e.w16, e.c10, e.w10};
    {mloc, mlow, mhic, mhiw} = {e.clo, e.wlo, e.chi, e.whi};
    @(posedge clk);
    #1;
    started = 1'b1;
    if (sbq.size() == 0) begin
      check("sb_empty", 32'(1), 32'(0));
    end else begin
      e = sbq.pop_front();
      check("cnt16", 32'(b16.count), 32'(e.c16));
      check("wr16",  32'(b16.Wrapped), 32'(e.w16));
      check("cnt10", 32'(b10.count), 32'(e.c10));
      check("wr10",  32'(b10.Wrapped), 32'(e.w10));
      check("cntlo", 32'(blo.count), 32'(e.clo));
      check("wrlo",  32'(blo.Wrapped), 32'(e.wlo));
      check("cnthi", 32'(bhi.count), 32'(e.chi));
      check("wrhi",  32'(bhi.Wrapped), 32'(e.whi));
    end
  endtask

  initial begin
    clr = 1'b1;
    b16.En = 0; b16.CarryIn = 0; b16.Load = 0; b16.LoadVal = 0;
    b10.En = 0; b10.CarryIn = 0; b10.Load = 0; b10.LoadVal = 0;
    blo.En = 0; blo.CarryIn = 1; blo.Load = 0; blo.LoadVal = 0;
    bhi.En = 0; bhi.Load = 0; bhi.LoadVal = 0;

    // Reset
    cycle(1, 0, 4'd0, 0, 0, 0);
    check("rst_cnt", 32'(b16.count), 32'(0));
    check("rst_wr",  32'(b16.Wrapped), 32'(0));
    check("rst_co",  32'(b16.CarryOut), 32'(0));

    // Free count: mod-16 and mod-10 side by side for 20 steps
    for (int i = 0; i < 20; i++) cycle(0, 0, 4'd0, 1, 1, 0);
    check("t1_cnt", 32'(b16.count), 32'(4));
    check("t1_wr",  32'(b16.Wrapped), 32'(1));
    check("t2_cnt", 32'(b10.count), 32'(0));

    // Load overrides enable, clears Wrapped, clamps above MODULUS-1
    cycle(0, 1, 4'd5, 0, 0, 0);
    cycle(0, 1, 4'd3, 1, 1, 0);
    check("t3_cnt", 32'(b16.count), 32'(3));
    check("t3_wr",  32'(b16.Wrapped), 32'(0));
    cycle(0, 1, 4'd12, 1, 1, 0);
    check("t3_clamp", 32'(b10.count), 32'(9));
    check("t3_noclamp", 32'(b16.count), 32'(12));

    // Step up to 15, then Load on the wrap cycle
    for (int i = 0; i < 3; i++) cycle(0, 0, 4'd0, 1, 1, 0);
    check("at15", 32'(b16.count), 32'(15));
    cycle(0, 1, 4'd2, 1, 1, 0);
    check("ldwrap_cnt", 32'(b16.count), 32'(2));
    check("ldwrap_wr",  32'(b16.Wrapped), 32'(0));

    // CarryIn gating
    cycle(1, 0, 4'd0, 0, 0, 0);
    cycle(0, 0, 4'd0, 1, 1, 0);
    cycle(0, 0, 4'd0, 1, 0, 0);
    cycle(0, 0, 4'd0, 1, 1, 0);
    cycle(0, 0, 4'd0, 1, 0, 0);
    check("t4_cnt", 32'(b16.count), 32'(2));

    // Clr beats Load; Clr at 15 with unknown enables
    cycle(0, 1, 4'd7, 0, 0, 0);
    cycle(1, 1, 4'd4, 1, 1, 0);
    check("t6_clrld", 32'(b16.count), 32'(0));
    cycle(0, 1, 4'd15, 0, 0, 0);
    cycle(1, 0, 4'd0, 1, 1, 1);
    check("t6_clr15", 32'(b16.count), 32'(0));

    // Two-digit cascade, 105 enables
    cycle(1, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 105; i++) cycle(0, 0, 4'd0, 1, 1, 0);
    check("t5_lo", 32'(blo.count), 32'(5));
    check("t5_hi", 32'(bhi.count), 32'(0));
    check("t5_hiwr", 32'(bhi.Wrapped), 32'(1));

    // Random mix
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1) | $urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
